// File: rtl/music_score_recorder.sv
// Live key capture: run-length encodes {note, octave} samples into 24-bit score words
// {length, note, octave} for the score RAM and closes each take with an EOF word.
module music_score_recorder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MIN_LEN = 2,
  parameter int unsigned EOF     = 15
) (
  input  logic              clk_1ms,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic              stop,
  input  logic [3:0]        key_note,
  input  logic [3:0]        key_octave,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic [ADDR_W-1:0] entry_count,
  output logic              recording,
  output logic              done,
  output logic              overflow
);

  localparam int unsigned LEN_W     = 16;
  localparam logic [LEN_W-1:0] LEN_MAX  = 16'hFFFF;
  localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_LEN);
  localparam logic [3:0]       EOF_CODE = 4'(EOF);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    RECORD = 3'd2,
    TERM   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  run_len;
  logic [3:0]        run_note;
  logic [3:0]        run_oct;

  // Sample normalisation: EOF code is a rest, and rests carry octave 0
  logic [3:0]       s_note;
  logic [3:0]       s_oct;
  logic             same_run;
  logic             addr_full;
  logic [LEN_W-1:0] len_out;

  always_comb begin
    s_note    = (key_note == EOF_CODE) ? 4'd0 : key_note;
    s_oct     = (s_note == 4'd0) ? 4'd0 : key_octave;
    same_run  = (s_note == run_note) && (s_oct == run_oct);
    addr_full = (addr == ADDR_LAST);
    len_out   = (run_len < LEN_MIN) ? LEN_MIN : run_len;
  end

  always_ff @(posedge clk_1ms or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      run_len     <= '0;
      run_note    <= '0;
      run_oct     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      entry_count <= '0;
      recording   <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (en) begin
        unique case (state)
          IDLE, DONE: begin
            if (start) begin
              state       <= ARMED;
              addr        <= '0;
              entry_count <= '0;
              overflow    <= 1'b0;
              done        <= 1'b0;
              recording   <= 1'b1;
            end
          end

          ARMED: begin
            if (stop) begin
              state     <= TERM;
              recording <= 1'b0;
            end else if (s_note != 4'd0) begin
              state    <= RECORD;
              run_note <= s_note;
              run_oct  <= s_oct;
              run_len  <= LEN_W'(1);
            end
          end

          RECORD: begin
            if (stop) begin
              // Flush the pending run unless it is a trailing rest
              state     <= TERM;
              recording <= 1'b0;
              if (run_note != 4'd0) begin
                if (addr_full) begin
                  overflow <= 1'b1;
                end else begin
                  wr_en       <= 1'b1;
                  wr_addr     <= addr;
                  wr_data     <= {len_out, run_note, run_oct};
                  addr        <= addr + 1'b1;
                  entry_count <= entry_count + 1'b1;
                end
              end
            end else if (!same_run || (run_len == LEN_MAX)) begin
              // Top address is kept free for the EOF word
              if (addr_full) begin
                overflow  <= 1'b1;
                state     <= TERM;
                recording <= 1'b0;
              end else begin
                wr_en       <= 1'b1;
                wr_addr     <= addr;
                wr_data     <= {len_out, run_note, run_oct};
                addr        <= addr + 1'b1;
                entry_count <= entry_count + 1'b1;
                run_note    <= s_note;
                run_oct     <= s_oct;
                run_len     <= LEN_W'(1);
              end
            end else begin
              run_len <= run_len + 16'd1;
            end
          end

          TERM: begin
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= {16'd0, EOF_CODE, 4'd0};
            state   <= DONE;
            done    <= 1'b1;
          end

          default: begin
            state     <= IDLE;
            recording <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_music_score_recorder.sv
// Directed bench for music_score_recorder: expected RAM writes go into a scoreboard
// queue; negedge monitors pop and compare on every wr_en.
module tb_music_score_recorder;

  logic clk_1ms = 1'b0;
  always #5 clk_1ms = ~clk_1ms;

  logic       rst, en, start, stop;
  logic [3:0] key_note, key_octave;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [23:0] wr_data;
  logic [7:0] entry_count;
  logic       recording, done, overflow;

  logic       start_b, stop_b;
  logic [3:0] key_note_b, key_octave_b;
  logic       wr_en_b;
  logic [1:0] wr_addr_b;
  logic [23:0] wr_data_b;
  logic [1:0] entry_count_b;
  logic       recording_b, done_b, overflow_b;

  music_score_recorder #(.ADDR_W(8), .MIN_LEN(2), .EOF(15)) dut (
    .clk_1ms(clk_1ms), .rst(rst), .en(en), .start(start), .stop(stop),
    .key_note(key_note), .key_octave(key_octave),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .entry_count(entry_count), .recording(recording), .done(done), .overflow(overflow)
  );

  music_score_recorder #(.ADDR_W(2), .MIN_LEN(2), .EOF(15)) dut_small (
    .clk_1ms(clk_1ms), .rst(rst), .en(en), .start(start_b), .stop(stop_b),
    .key_note(key_note_b), .key_octave(key_octave_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .entry_count(entry_count_b), .recording(recording_b), .done(done_b), .overflow(overflow_b)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] q[$];
  logic [31:0] qb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [15:0] len, input logic [3:0] n,
                           input logic [3:0] o);
    q.push_back({a, len, n, o});
  endtask

  task automatic expect_wr_b(input logic [7:0] a, input logic [15:0] len, input logic [3:0] n,
                             input logic [3:0] o);
    qb.push_back({a, len, n, o});
  endtask

  // Monitors: every write strobe must match the oldest expected word
  always @(negedge clk_1ms) begin
    if (wr_en === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h expected none", {wr_addr, wr_data});
      end else begin
        logic [31:0] e;
        e = q.pop_front();
        chk("write", {wr_addr, wr_data}, e);
      end
    end
    if (wr_en_b === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write_small: got %0h expected none", {6'd0, wr_addr_b, wr_data_b});
      end else begin
        logic [31:0] e;
        e = qb.pop_front();
        chk("write_small", {6'd0, wr_addr_b, wr_data_b}, e);
      end
    end
  end

  task automatic step(input logic [3:0] n, input logic [3:0] o, input logic st, input logic sp);
    key_note = n; key_octave = o; start = st; stop = sp;
    @(posedge clk_1ms); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic hold(input logic [3:0] n, input logic [3:0] o, input int cycles);
    for (int i = 0; i < cycles; i++) step(n, o, 1'b0, 1'b0);
  endtask

  task automatic step_b(input logic [3:0] n, input logic [3:0] o, input logic st);
    key_note_b = n; key_octave_b = o; start_b = st;
    @(posedge clk_1ms); #1;
    start_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0; key_note = '0; key_octave = '0;
    start_b = 1'b0; stop_b = 1'b0; key_note_b = '0; key_octave_b = '0;
    #12;
    chk("reset_outputs", {wr_en, wr_addr, entry_count, recording, done, overflow}, 32'd0);
    chk("reset_data", wr_data, 32'd0);
    @(posedge clk_1ms); #1 rst = 1'b0;

    // Basic take with leading rests
    expect_wr(8'd0, 16'd10, 4'd5, 4'd4);
    expect_wr(8'd1, 16'd4, 4'd7, 4'd4);
    expect_wr(8'd2, 16'd0, 4'd15, 4'd0);
    step(4'd0, 4'd0, 1'b1, 1'b0);
    hold(4'd0, 4'd3, 3);
    hold(4'd5, 4'd4, 10);
    chk("t1_recording", recording, 32'd1);
    hold(4'd7, 4'd4, 4);
    step(4'd0, 4'd0, 1'b0, 1'b1);
    step(4'd0, 4'd0, 1'b0, 1'b0);
    chk("t1_done", done, 32'd1);
    chk("t1_count", entry_count, 32'd2);
    chk("t1_recording_off", recording, 32'd0);

    // Single-cycle glitch is floored to the minimum length
    expect_wr(8'd0, 16'd3, 4'd5, 4'd4);
    expect_wr(8'd1, 16'd2, 4'd3, 4'd4);
    expect_wr(8'd2, 16'd3, 4'd5, 4'd4);
    expect_wr(8'd3, 16'd0, 4'd15, 4'd0);
    step(4'd0, 4'd0, 1'b1, 1'b0);
    chk("t2_done_cleared", done, 32'd0);
    hold(4'd5, 4'd4, 3);
    hold(4'd3, 4'd4, 1);
    hold(4'd5, 4'd4, 3);
    step(4'd0, 4'd0, 1'b0, 1'b1);
    step(4'd0, 4'd0, 1'b0, 1'b0);
    chk("t2_count", entry_count, 32'd3);

    // Length saturation splits a long hold into two entries
    expect_wr(8'd0, 16'hFFFF, 4'd1, 4'd2);
    expect_wr(8'd1, 16'd2, 4'd1, 4'd2);
    expect_wr(8'd2, 16'd0, 4'd15, 4'd0);
    step(4'd0, 4'd0, 1'b1, 1'b0);
    hold(4'd1, 4'd2, 65537);
    step(4'd0, 4'd0, 1'b0, 1'b1);
    step(4'd0, 4'd0, 1'b0, 1'b0);
    chk("t3_count", entry_count, 32'd2);
    chk("t3_done", done, 32'd1);

    // Empty take
    expect_wr(8'd0, 16'd0, 4'd15, 4'd0);
    step(4'd0, 4'd0, 1'b1, 1'b0);
    step(4'd0, 4'd0, 1'b0, 1'b1);
    step(4'd0, 4'd0, 1'b0, 1'b0);
    chk("t5_empty_count", entry_count, 32'd0);
    chk("t5_empty_done", done, 32'd1);

    // Trailing rest dropped; EOF code input behaves as a rest
    expect_wr(8'd0, 16'd2, 4'd9, 4'd3);
    expect_wr(8'd1, 16'd0, 4'd15, 4'd0);
    step(4'd0, 4'd0, 1'b1, 1'b0);
    hold(4'd9, 4'd3, 2);
    hold(4'd0, 4'd0, 3);
    hold(4'd15, 4'd5, 3);
    step(4'd0, 4'd0, 1'b0, 1'b1);
    step(4'd0, 4'd0, 1'b0, 1'b0);
    chk("t5_rest_count", entry_count, 32'd1);

    // Clock enable freezes the run length
    expect_wr(8'd0, 16'd7, 4'd4, 4'd4);
    expect_wr(8'd1, 16'd0, 4'd15, 4'd0);
    step(4'd0, 4'd0, 1'b1, 1'b0);
    hold(4'd4, 4'd4, 5);
    en = 1'b0;
    hold(4'd6, 4'd4, 3);
    chk("t6_en_recording", recording, 32'd1);
    en = 1'b1;
    hold(4'd4, 4'd4, 2);
    step(4'd0, 4'd0, 1'b0, 1'b1);
    step(4'd0, 4'd0, 1'b0, 1'b0);
    chk("t6_en_count", entry_count, 32'd1);

    // Small RAM overflows before stop
    expect_wr_b(8'd0, 16'd2, 4'd1, 4'd4);
    expect_wr_b(8'd1, 16'd2, 4'd2, 4'd4);
    expect_wr_b(8'd2, 16'd2, 4'd1, 4'd4);
    expect_wr_b(8'd3, 16'd0, 4'd15, 4'd0);
    step_b(4'd0, 4'd0, 1'b1);
    step_b(4'd1, 4'd4, 1'b0);
    step_b(4'd2, 4'd4, 1'b0);
    step_b(4'd1, 4'd4, 1'b0);
    step_b(4'd2, 4'd4, 1'b0);
    step_b(4'd1, 4'd4, 1'b0);
    step_b(4'd0, 4'd0, 1'b0);
    chk("t4_overflow", overflow_b, 32'd1);
    chk("t4_done", done_b, 32'd1);
    chk("t4_count", entry_count_b, 32'd3);
    chk("t4_recording", recording_b, 32'd0);
    step_b(4'd0, 4'd0, 1'b0);
    chk("t4_overflow_sticky", overflow_b, 32'd1);

    // Asynchronous reset aborts a take with no EOF
    expect_wr(8'd0, 16'd3, 4'd2, 4'd1);
    step(4'd0, 4'd0, 1'b1, 1'b0);
    hold(4'd2, 4'd1, 3);
    hold(4'd3, 4'd1, 2);
    chk("t6_pre_count", entry_count, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_outputs", {wr_en, entry_count, recording, done, overflow}, 32'd0);
    chk("t6_rst_small", {overflow_b, done_b}, 32'd0);
    @(posedge clk_1ms); #1 rst = 1'b0;
    hold(4'd3, 4'd1, 3);
    chk("t6_idle_after_rst", {recording, wr_en, done}, 32'd0);

    hold(4'd0, 4'd0, 2);
    chk("scoreboard_drained", q.size(), 32'd0);
    chk("scoreboard_small_drained", qb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
